// File: rtl/seq_divider_if.sv
// Handshake and data bundle for seq_divider: the requester drives start and operands,
// the divider returns status and results.
interface seq_divider_if #(
  parameter int unsigned W = 17
) ();
  logic             start;
  logic [2*W-1:0]   dividend;
  logic [W-1:0]     divisor;
  logic             busy;
  logic             done;
  logic [W-1:0]     quotient;
  logic [W-1:0]     remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential signed divider: restoring radix-2 on magnitudes, one quotient bit per clock.
// Define DIV_FLOOR_EN for floor-division semantics; the default truncates toward zero.
module seq_divider #(
  parameter int unsigned W = 17
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave div_if
);
  localparam int unsigned     DW       = 2 * W;
  localparam int unsigned     CntW     = $clog2(DW);
  localparam logic [CntW-1:0] LastIter = CntW'(DW - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StZero} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  logic [DW-1:0]   dvd_q, dvd_d;
  logic [W-1:0]    dsr_q, dsr_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            sdvd_q, sdvd_d, sdsr_q, sdsr_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            dbz_q, dbz_d, ovf_q, ovf_d;
  logic [W-1:0]    quo_q, quo_d, rmd_q, rmd_d;

  logic [W:0]      shifted, trial;
  logic [DW:0]     q_fix;
  logic [W-1:0]    r_fix;
  logic            ovf_fix;
`ifdef DIV_FLOOR_EN
  logic [W-1:0]    dsr_s;
`endif

  // Partial remainder stays below the divisor magnitude, so W+1 bits cover the trial.
  assign shifted = {rem_q, dvd_q[DW-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  always_comb begin
    q_fix = (sdvd_q ^ sdsr_q) ? -{1'b0, dvd_q} : {1'b0, dvd_q};
    r_fix = sdvd_q ? -rem_q : rem_q;
`ifdef DIV_FLOOR_EN
    dsr_s = sdsr_q ? -dsr_q : dsr_q;
    if ((r_fix != '0) && (r_fix[W-1] != sdsr_q)) begin
      q_fix = q_fix - 1'b1;
      r_fix = r_fix + dsr_s;
    end
`endif
    // Representable iff every bit from the W-bit sign position upward agrees.
    ovf_fix = !((&q_fix[DW:W-1]) || !(|q_fix[DW:W-1]));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    sdvd_d  = sdvd_q;
    sdsr_d  = sdsr_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;

    unique case (state_q)
      StIdle: begin
        if (div_if.start) begin
          sdvd_d  = div_if.dividend[DW-1];
          sdsr_d  = div_if.divisor[W-1];
          dvd_d   = div_if.dividend[DW-1] ? -div_if.dividend : div_if.dividend;
          dsr_d   = div_if.divisor[W-1] ? -div_if.divisor : div_if.divisor;
          rem_d   = '0;
          cnt_d   = '0;
          quo_d   = '0;
          rmd_d   = '0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = (div_if.divisor == '0) ? StZero : StCalc;
        end
      end
      StCalc: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (!trial[W]) begin
          rem_d = trial[W-1:0];
          dvd_d = {dvd_q[DW-2:0], 1'b1};
        end else begin
          rem_d = shifted[W-1:0];
          dvd_d = {dvd_q[DW-2:0], 1'b0};
        end
        if (cnt_q == LastIter) state_d = StFix;
      end
      StFix: begin
        quo_d   = q_fix[W-1:0];
        rmd_d   = r_fix;
        ovf_d   = ovf_fix;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StZero: begin
        quo_d   = '0;
        rmd_d   = '0;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      sdvd_q  <= 1'b0;
      sdsr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      sdvd_q  <= sdvd_d;
      sdsr_q  <= sdsr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  assign div_if.busy        = busy_q;
  assign div_if.done        = done_q;
  assign div_if.quotient    = quo_q;
  assign div_if.remainder   = rmd_q;
  assign div_if.div_by_zero = dbz_q;
  assign div_if.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: issued operations push model results, a monitor
// pops and compares on every done pulse. Honours DIV_FLOOR_EN like the design.
module tb_seq_divider;
  localparam int unsigned W = 17;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    longint       done_cyc;
    int           busy_n;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  int     busy_cnt = 0;
  exp_t   exp_q[$];

  seq_divider_if #(.W(W)) dif ();

  seq_divider #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: plain integer division, truncating toward zero (optionally floored).
  function automatic exp_t model(input logic signed [2*W-1:0] a, input logic signed [W-1:0] b);
    exp_t   e;
    longint sa, sb, q, r;
    sa = a;
    sb = b;
    e.done_cyc = 0;
    if (sb == 0) begin
      e.q = '0; e.r = '0; e.dbz = 1'b1; e.ovf = 1'b0; e.busy_n = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
`ifdef DIV_FLOOR_EN
      if (r != 0 && ((r < 0) != (sb < 0))) begin
        q = q - 1;
        r = r + sb;
      end
`endif
      e.q      = q[W-1:0];
      e.r      = r[W-1:0];
      e.dbz    = 1'b0;
      e.ovf    = (q > 65535) || (q < -65536);
      e.busy_n = 2 * W;
    end
    return e;
  endfunction

  // Call with the clock low and the divider able to accept.
  task automatic issue(input logic signed [2*W-1:0] a, input logic signed [W-1:0] b);
    exp_t e;
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(posedge clk);
    #1;
    dif.start    = 1'b0;
    dif.dividend = (2*W)'($urandom);
    dif.divisor  = W'($urandom);
    e = model(a, b);
    e.done_cyc = cyc + ((b == 0) ? 1 : 2 * W + 1);
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (dif.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 64'(dif.busy), 64'd0);
    check({tag, "_done"}, 64'(dif.done), 64'd0);
    check({tag, "_quotient"}, 64'(dif.quotient), 64'd0);
    check({tag, "_remainder"}, 64'(dif.remainder), 64'd0);
    check({tag, "_div_by_zero"}, 64'(dif.div_by_zero), 64'd0);
    check({tag, "_overflow"}, 64'(dif.overflow), 64'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (dif.busy) busy_cnt++;
      if (dif.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(dif.done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("quotient", 64'(dif.quotient), 64'(e.q));
          check("remainder", 64'(dif.remainder), 64'(e.r));
          check("div_by_zero", 64'(dif.div_by_zero), 64'(e.dbz));
          check("overflow", 64'(dif.overflow), 64'(e.ovf));
          check("latency", 64'(cyc), 64'(e.done_cyc));
          check("busy_cycles", 64'(busy_cnt), 64'(e.busy_n));
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [2*W-1:0] a;
    logic signed [W-1:0]   b;
    logic [63:0]           r64;
    longint                chain;

    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    #2 rst = 1'b1;
    #2 check_cleared("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(34'sd40320, 17'sd8);          wait_done();
    issue(-34'sd7, 17'sd2);             wait_done();
    issue(34'sd7, -17'sd2);             wait_done();
    issue(34'sd123, 17'sd0);            wait_done();
    issue(34'sd65536, 17'sd1);          wait_done();
    issue(-34'sd65536, 17'sd1);         wait_done();
    issue(-34'sh2_0000_0000, -17'sd1);  wait_done();
    issue(-34'sh2_0000_0000, 17'sd1);   wait_done();
    issue(34'sd1000, -17'sd65536);      wait_done();
    issue(-34'sd7, -17'sd2);            wait_done();

    // Unwind 8!: each start lands in the done cycle of the previous division.
    chain = 40320;
    for (int d = 8; d >= 2; d--) begin
      issue(34'(chain), 17'(d));
      wait_done();
      chain = chain / d;
    end

    // Start pulsed mid-calculation must be ignored.
    issue(34'sd999_999, 17'sd37);
    repeat (5) @(negedge clk);
    dif.start = 1'b1; dif.dividend = 34'sd5; dif.divisor = 17'sd0;
    @(negedge clk);
    dif.start = 1'b0;
    wait_done();

    // Asynchronous reset mid-calculation discards the division.
    issue(34'sd123_456, 17'sd789);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1 check_cleared("midreset");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(34'sd40320, 17'sd8);
    wait_done();

    for (int n = 0; n < 40; n++) begin
      r64 = {$urandom, $urandom};
      a = r64[2*W-1:0];
      if ($urandom_range(0, 2) == 0) a = 34'(signed'(r64[15:0]));
      b = W'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1, 2:    b = W'(signed'(4'($urandom_range(0, 15)))) | 17'sd1;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(a, b);
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential signed divider, the inverse companion of the team's Booth multiplier.
- Takes a 2W-bit dividend (product-width) and a W-bit divisor; returns a W-bit quotient and a W-bit remainder.
- Restoring radix-2 algorithm on magnitudes, one quotient bit per clock.
- start/busy/done handshake, so a product from the multiplier can be divided back (e.g. factorial unwinding).

Parameters:
- W, 17, operand width; dividend is 2W bits, divisor/quotient/remainder are W bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while idle
- dividend  input  2W  signed two's-complement dividend; sampled on accept
- divisor  input  W  signed two's-complement divisor; sampled on accept
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  W  signed quotient (low W bits of true quotient)
- remainder  output  W  signed remainder
- div_by_zero  output  1  divisor was zero
- overflow  output  1  true quotient not representable in signed W bits

Behaviour:
- Reset (async, any time, including mid-division):
  - state=IDLE
  - busy, done, quotient, remainder, div_by_zero and overflow all 0
  - any in-flight division is discarded; no done is produced for it
- States:
  - IDLE: start=1 at edge k → accept:
    - latch sign of dividend, sign of divisor, and both magnitudes (2W-bit and W-bit unsigned; the most-negative values must be handled)
    - clear div_by_zero and overflow
    - divisor==0 → go to ZERO; else → go to CALC with iteration counter=0
  - CALC: 2W iterations at edges k+1..k+2W. Each iteration:
    - shift partial remainder left, bringing in the next dividend bit (MSB first)
    - trial-subtract the divisor magnitude; if non-negative, keep the result and set the quotient bit to 1
    - partial remainder is W+1 bits wide
  - FIX (edge k+2W+1):
    - apply signs: quotient negative iff operand signs differ; remainder takes the dividend sign (truncation toward zero)
    - register quotient (low W bits) and remainder
    - overflow=1 iff the signed quotient lies outside [-2^(W-1), 2^(W-1)-1]
    - done=1, busy=0, return to IDLE
  - ZERO (edge k+1): quotient=0, remainder=0, div_by_zero=1, done=1, busy=0, return to IDLE.
- Latency from the accept edge to the done edge:
  - normal division: 2W+1 clocks (35 for W=17)
  - divide-by-zero: 1 clock
- busy:
  - goes high on the edge after the accept edge
  - stays high through the CALC iterations
  - goes low on the same edge that raises done
- done is a single-cycle pulse.
- Outputs and flags hold their values until the next accept edge, then clear.
- start while busy is ignored; it is not queued.
- start in the cycle done is high is accepted: back-to-back operation, no idle gap.
- Inputs are don't-care except on the accept edge.

Optional Feature:
- Macro: DIV_FLOOR_EN.
- Defined: floor-division semantics.
  - After the sign fix, if remainder≠0 and its sign differs from the divisor sign: quotient -= 1 and remainder += divisor.
  - The correction is applied in the same FIX cycle, so latency is unchanged.
  - overflow is evaluated on the corrected quotient.
- Undefined: truncation toward zero; the remainder sign follows the dividend.

Test Plan:
- dividend=40320 (8!), divisor=8 → quotient=5040, remainder=0, overflow=0, done exactly 35 clocks after the accept edge, busy high for 34 cycles.
- dividend=-7, divisor=2 → quotient=-3, remainder=-1. With DIV_FLOOR_EN: quotient=-4, remainder=1. Also dividend=7, divisor=-2 → -3/1, or -4/-1 with floor.
- divisor=0, dividend=123 → done 1 clock after accept, div_by_zero=1, quotient=0, remainder=0, busy never high.
- Overflow boundaries:
  - dividend=65536, divisor=1 → overflow=1, quotient=17'h10000
  - dividend=-65536, divisor=1 → overflow=0, quotient=17'h10000
  - dividend=-2^33, divisor=-1 → overflow=1
- Unwind chain:
  - divide 40320 by 8, 7, ... 2, issuing each start in the cycle done is high with the previous quotient as dividend
  - all accepted with no gap; final quotient=1, all remainders=0
- Mid-operation disturbances:
  - start pulsed at CALC iteration 5 → ignored, original result still correct
  - rst asserted at iteration 10 → busy=0 and all outputs 0 immediately (async), no done pulse; next start completes normally
